sa2x2_skew_feeder: RTL and testbench

Upstream feeder for the 2x2 systolic array. It accepts one unskewed 2x2 operand pair (data matrix A, weight matrix B) per valid/ready handshake. It drives the array's per-cycle operand pins in the diagonal-skewed order the array expects, and generates the array's `in_valid`. Consecutive operand pairs are overlapped so the array sustains one matrix product every 2 cycles.

---
 rtl/sa2x2_pkg.sv | 24 ++
 rtl/sa2x2_skew_slot.sv | 92 +++++++++
 rtl/sa2x2_skew_feeder.sv | 121 ++++++++++++
 tb/tb_sa2x2_skew_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa2x2_pkg.sv
// Shared constants, matrix type and slot-rotation helper for the 2x2 systolic
// array skew feeder.
package sa2x2_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int NUM_SLOTS  = 3;

  localparam logic [2:0] OFF_W0   = 3'd0;
  localparam logic [2:0] OFF_D0   = 3'd2;
  localparam logic [2:0] OFF_LAST = 3'd4;
  localparam logic [2:0] OFF_TAIL = 3'd5;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] e00;
    logic [DATA_WIDTH-1:0] e01;
    logic [DATA_WIDTH-1:0] e10;
    logic [DATA_WIDTH-1:0] e11;
  } mat2x2_t;

  function automatic logic [1:0] next_slot(input logic [1:0] cur);
    return (cur == 2'(NUM_SLOTS - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/sa2x2_skew_slot.sv
// One in-flight operand set: holds A/B plus its schedule offset and emits the
// pin contributions for the offset that becomes visible after the next edge.
module sa2x2_skew_slot #(
  parameter int DATA_WIDTH = sa2x2_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*DATA_WIDTH-1:0] a_in,
  input  logic [4*DATA_WIDTH-1:0] b_in,
  output logic [4*DATA_WIDTH-1:0] a_pins,
  output logic [4*DATA_WIDTH-1:0] b_pins,
  output logic                    active,
  output logic                    valid
);
  import sa2x2_pkg::*;

  localparam int W = DATA_WIDTH;

  logic                    active_r;
  logic [2:0]              phase_r;
  logic [4*DATA_WIDTH-1:0] a_r;
  logic [4*DATA_WIDTH-1:0] b_r;

  logic                    active_nx_s;
  logic [2:0]              phase_nx_s;
  logic [4*DATA_WIDTH-1:0] a_nx_s;
  logic [4*DATA_WIDTH-1:0] b_nx_s;

  // Next slot state, and the pins it drives; the top registers these so they
  // line up with the offset being entered rather than the one being left.
  always_comb begin
    active_nx_s = 1'b0;
    phase_nx_s  = OFF_W0;
    a_nx_s      = a_r;
    b_nx_s      = b_r;
    a_pins      = {(4*W){1'b0}};
    b_pins      = {(4*W){1'b0}};
    if (load) begin
      active_nx_s = 1'b1;
      phase_nx_s  = OFF_W0;
      a_nx_s      = a_in;
      b_nx_s      = b_in;
    end else if (active_r && (phase_r != OFF_TAIL)) begin
      active_nx_s = 1'b1;
      phase_nx_s  = phase_r + 3'd1;
    end else begin
      active_nx_s = 1'b0;
      phase_nx_s  = OFF_W0;
    end
    if (active_nx_s) begin
      case (phase_nx_s)
        OFF_W0: b_pins[1*W +: W] = b_nx_s[1*W +: W];
        3'd1: begin
          b_pins[0*W +: W] = b_nx_s[0*W +: W];
          b_pins[2*W +: W] = b_nx_s[2*W +: W];
        end
        OFF_D0: begin
          b_pins[3*W +: W] = b_nx_s[3*W +: W];
          a_pins[0*W +: W] = a_nx_s[0*W +: W];
        end
        3'd3: begin
          a_pins[1*W +: W] = a_nx_s[1*W +: W];
          a_pins[2*W +: W] = a_nx_s[2*W +: W];
        end
        OFF_LAST: a_pins[3*W +: W] = a_nx_s[3*W +: W];
        default: a_pins = {(4*W){1'b0}};
      endcase
    end else begin
      a_pins = {(4*W){1'b0}};
    end
  end

  assign active = active_nx_s;
  assign valid  = active_nx_s && (phase_nx_s >= OFF_D0);

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= 1'b0;
      phase_r  <= OFF_W0;
      a_r      <= {(4*W){1'b0}};
      b_r      <= {(4*W){1'b0}};
    end else begin
      active_r <= active_nx_s;
      phase_r  <= phase_nx_s;
      a_r      <= a_nx_s;
      b_r      <= b_nx_s;
    end
  end

endmodule

// File: rtl/sa2x2_skew_feeder.sv
// Skew feeder for the 2x2 systolic array: accepts unskewed A/B pairs and
// drives them diagonally skewed onto the array pins, overlapping up to 3 sets.
module sa2x2_skew_feeder #(
  parameter int DATA_WIDTH = sa2x2_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a00,
  input  logic [DATA_WIDTH-1:0] s_a01,
  input  logic [DATA_WIDTH-1:0] s_a10,
  input  logic [DATA_WIDTH-1:0] s_a11,
  input  logic [DATA_WIDTH-1:0] s_b00,
  input  logic [DATA_WIDTH-1:0] s_b01,
  input  logic [DATA_WIDTH-1:0] s_b10,
  input  logic [DATA_WIDTH-1:0] s_b11,
  output logic [DATA_WIDTH-1:0] a00,
  output logic [DATA_WIDTH-1:0] a01,
  output logic [DATA_WIDTH-1:0] a10,
  output logic [DATA_WIDTH-1:0] a11,
  output logic [DATA_WIDTH-1:0] b00,
  output logic [DATA_WIDTH-1:0] b01,
  output logic [DATA_WIDTH-1:0] b10,
  output logic [DATA_WIDTH-1:0] b11,
  output logic                  in_valid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  issued_cnt
);
  import sa2x2_pkg::*;

  localparam int W = DATA_WIDTH;

  logic                 issued_last_r;
  logic [1:0]           slot_ptr_r;
  logic [CNT_WIDTH-1:0] issued_cnt_r;
  logic [4*W-1:0]       a_out_r;
  logic [4*W-1:0]       b_out_r;
  logic                 in_valid_r;
  logic                 busy_r;

  logic                 accept_s;
  logic [4*W-1:0]       a_in_s;
  logic [4*W-1:0]       b_in_s;
  logic [4*W-1:0]       a_or_s;
  logic [4*W-1:0]       b_or_s;
  logic [4*W-1:0]       a_pins_s [NUM_SLOTS];
  logic [4*W-1:0]       b_pins_s [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] load_s;
  logic [NUM_SLOTS-1:0] active_s;
  logic [NUM_SLOTS-1:0] valid_s;

  // Two-cycle issue spacing plus a 6-cycle set lifetime means round-robin
  // reuse never lands on a slot that is still in flight.
  assign s_ready  = !rst && !issued_last_r;
  assign accept_s = s_valid && s_ready;
  assign a_in_s   = {s_a11, s_a10, s_a01, s_a00};
  assign b_in_s   = {s_b11, s_b10, s_b01, s_b00};

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign load_s[k] = accept_s && (slot_ptr_r == 2'(k));
    sa2x2_skew_slot #(.DATA_WIDTH(W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load_s[k]),
      .a_in   (a_in_s),
      .b_in   (b_in_s),
      .a_pins (a_pins_s[k]),
      .b_pins (b_pins_s[k]),
      .active (active_s[k]),
      .valid  (valid_s[k])
    );
  end

  // Overlapping sets never drive the same pin in the same cycle, so OR merges them.
  always_comb begin
    a_or_s = {(4*W){1'b0}};
    b_or_s = {(4*W){1'b0}};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      a_or_s = a_or_s | a_pins_s[k];
      b_or_s = b_or_s | b_pins_s[k];
    end
  end

  // Issue control, set counter and the registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_last_r <= 1'b0;
      slot_ptr_r    <= 2'd0;
      issued_cnt_r  <= {CNT_WIDTH{1'b0}};
      a_out_r       <= {(4*W){1'b0}};
      b_out_r       <= {(4*W){1'b0}};
      in_valid_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      issued_last_r <= accept_s;
      if (accept_s) begin
        slot_ptr_r   <= next_slot(slot_ptr_r);
        issued_cnt_r <= issued_cnt_r + CNT_WIDTH'(1);
      end
      a_out_r    <= a_or_s;
      b_out_r    <= b_or_s;
      in_valid_r <= |valid_s;
      busy_r     <= |active_s;
    end
  end

  assign a00        = a_out_r[0*W +: W];
  assign a01        = a_out_r[1*W +: W];
  assign a10        = a_out_r[2*W +: W];
  assign a11        = a_out_r[3*W +: W];
  assign b00        = b_out_r[0*W +: W];
  assign b01        = b_out_r[1*W +: W];
  assign b10        = b_out_r[2*W +: W];
  assign b11        = b_out_r[3*W +: W];
  assign in_valid   = in_valid_r;
  assign busy       = busy_r;
  assign issued_cnt = issued_cnt_r;

endmodule

// File: tb/tb_sa2x2_skew_feeder.sv
// Randomized self-checking bench for sa2x2_skew_feeder against a schedule-table
// model of accepted sets (offset = cycles since accept).
module tb_sa2x2_skew_feeder;
  import sa2x2_pkg::*;

  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_a00, s_a01, s_a10, s_a11, s_b00, s_b01, s_b10, s_b11;
  logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
  logic          in_valid;
  logic          busy;
  logic [CW-1:0] issued_cnt;

  always #5 clk = ~clk;

  sa2x2_skew_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_a00(s_a00), .s_a01(s_a01), .s_a10(s_a10), .s_a11(s_a11),
    .s_b00(s_b00), .s_b01(s_b01), .s_b10(s_b10), .s_b11(s_b11),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .in_valid(in_valid), .busy(busy), .issued_cnt(issued_cnt)
  );

  typedef struct {
    int      e;
    mat2x2_t a;
    mat2x2_t b;
  } set_t;

  set_t sets[$];
  int   cyc = 0;
  bit   last_acc = 1'b0;
  int   acc_total = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic mat2x2_t rand_mat();
    return mat2x2_t'(16'($urandom));
  endfunction

  function automatic logic [35:0] obs_vec();
    return {a00, a01, a10, a11, b00, b01, b10, b11, in_valid, busy, issued_cnt};
  endfunction

  // Expected pins from the schedule table: B01 | B00,B10 | B11,A00 | A01,A10 | A11.
  function automatic logic [35:0] exp_vec();
    mat2x2_t pa, pb;
    logic    iv, bz;
    int      d;
    pa = '0; pb = '0; iv = 1'b0; bz = 1'b0;
    foreach (sets[i]) begin
      d = cyc - sets[i].e;
      case (d)
        0: pb.e01 = pb.e01 | sets[i].b.e01;
        1: begin pb.e00 = pb.e00 | sets[i].b.e00; pb.e10 = pb.e10 | sets[i].b.e10; end
        2: begin pb.e11 = pb.e11 | sets[i].b.e11; pa.e00 = pa.e00 | sets[i].a.e00; end
        3: begin pa.e01 = pa.e01 | sets[i].a.e01; pa.e10 = pa.e10 | sets[i].a.e10; end
        4: pa.e11 = pa.e11 | sets[i].a.e11;
        default: ;
      endcase
      if (d >= 2 && d <= 5) iv = 1'b1;
      if (d >= 0 && d <= 5) bz = 1'b1;
    end
    return {pa.e00, pa.e01, pa.e10, pa.e11, pb.e00, pb.e01, pb.e10, pb.e11,
            iv, bz, CW'(acc_total)};
  endfunction

  task automatic model_clear();
    sets.delete();
    acc_total = 0;
    last_acc  = 1'b0;
  endtask

  // One clock of stimulus: drive at/after negedge, advance model at posedge,
  // return at the following negedge.
  task automatic advance(input bit v, input mat2x2_t a, input mat2x2_t b,
                         output bit rdy_obs, output bit rdy_exp);
    bit acc;
    s_valid = v;
    s_a00 = a.e00; s_a01 = a.e01; s_a10 = a.e10; s_a11 = a.e11;
    s_b00 = b.e00; s_b01 = b.e01; s_b10 = b.e10; s_b11 = b.e11;
    #1;
    rdy_obs = s_ready;
    rdy_exp = !rst && !last_acc;
    acc = v && rdy_exp;
    @(posedge clk);
    cyc++;
    if (rst) model_clear();
    else begin
      if (acc) begin
        sets.push_back('{cyc, a, b});
        acc_total++;
      end
      last_acc = acc;
    end
    while (sets.size() > 0 && (cyc - sets[0].e) > 5) sets.delete(0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit ro, re;
    rst = 1'b1;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_outputs actual=%h required=%h", obs_vec(), exp_vec());
    end
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready actual=%b required=0", s_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_s_ready actual=%b required=1", s_ready);
    end
    advance(1'b0, rand_mat(), rand_mat(), ro, re);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_idle actual=%h required=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_set();
    mat2x2_t a, b;
    bit ro, re;
    apply_reset();
    a = '{4'd4, 4'd3, 4'd12, 4'd4};
    b = '{4'd4, 4'd2, 4'd6, 4'd8};
    advance(1'b1, a, b, ro, re);
    checks++;
    if (ro !== 1'b1) begin
      errors++; $display("FAIL single_accept_ready actual=%b required=1", ro);
    end
    for (int i = 0; i <= 6; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_pins t+%0d actual=%h required=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (in_valid !== ((i >= 2 && i <= 5) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL single_in_valid t+%0d actual=%b", i, in_valid);
      end
      if (i == 0) begin
        checks++;
        if (b01 !== 4'd2) begin
          errors++; $display("FAIL single_b01_first actual=%0d required=2", b01);
        end
      end
      if (i == 6) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL single_busy_end actual=%b required=0", busy);
        end
      end
      advance(1'b0, a, b, ro, re);
    end
  endtask

  task automatic test_back_to_back();
    mat2x2_t ma[3];
    mat2x2_t mb[3];
    bit ro, re;
    int iv_cnt, idx;
    apply_reset();
    ma[0] = '{4'd4, 4'd3, 4'd12, 4'd4};  mb[0] = '{4'd4, 4'd2, 4'd6, 4'd8};
    ma[1] = '{4'd12, 4'd14, 4'd10, 4'd1}; mb[1] = '{4'd7, 4'd4, 4'd8, 4'd1};
    ma[2] = '{4'd2, 4'd3, 4'd4, 4'd9};   mb[2] = '{4'd3, 4'd1, 4'd5, 4'd7};
    iv_cnt = 0;
    for (int k = 0; k <= 11; k++) begin
      idx = (k <= 4) ? k / 2 : 2;
      advance((k % 2 == 0) && (k <= 4), ma[idx], mb[idx], ro, re);
      checks++;
      if (ro !== re) begin
        errors++; $display("FAIL b2b_s_ready k=%0d actual=%b required=%b", k, ro, re);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_pins t+%0d actual=%h required=%h", k, obs_vec(), exp_vec());
      end
      if (k >= 2 && k <= 9 && in_valid === 1'b1) iv_cnt++;
      if (k == 4) begin
        checks++;
        if ({a00, a11, b01, b11} !== {4'd12, 4'd4, 4'd1, 4'd1}) begin
          errors++; $display("FAIL b2b_t4_pins actual=%h required=c411", {a00, a11, b01, b11});
        end
      end
      if (k == 10) begin
        checks++;
        if (issued_cnt !== 2'd3) begin
          errors++; $display("FAIL b2b_issued_cnt actual=%0d required=3", issued_cnt);
        end
      end
    end
    checks++;
    if (iv_cnt != 8) begin
      errors++; $display("FAIL b2b_in_valid_continuous actual=%0d required=8", iv_cnt);
    end
  endtask

  task automatic test_backpressure();
    mat2x2_t a, b;
    bit ro, re;
    apply_reset();
    a = rand_mat(); b = rand_mat();
    for (int k = 0; k < 12; k++) begin
      advance(1'b1, a, b, ro, re);
      checks++;
      if (ro !== ((k % 2 == 0) ? 1'b1 : 1'b0) || ro !== re) begin
        errors++; $display("FAIL bp_s_ready k=%0d actual=%b required=%b", k, ro, re);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_pins k=%0d actual=%h required=%h", k, obs_vec(), exp_vec());
      end
      if (last_acc) begin a = rand_mat(); b = rand_mat(); end
    end
    for (int k = 0; k < 7; k++) begin
      advance(1'b0, a, b, ro, re);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_drain k=%0d actual=%h required=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    mat2x2_t a, b;
    bit pending, ro, re;
    pending = 1'b0;
    a = rand_mat(); b = rand_mat();
    for (int k = 0; k < 400; k++) begin
      if (!pending) begin
        pending = ($urandom_range(0, 2) != 0);
        a = rand_mat(); b = rand_mat();
      end
      advance(pending, a, b, ro, re);
      if (last_acc) pending = 1'b0;
      checks++;
      if (ro !== re) begin
        errors++; $display("FAIL rand_s_ready k=%0d actual=%b required=%b", k, ro, re);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_pins k=%0d actual=%h required=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midflight();
    mat2x2_t a, b;
    bit ro, re;
    apply_reset();
    a = rand_mat(); b = rand_mat();
    a.e01 = 4'hF;
    advance(1'b1, a, b, ro, re);
    advance(1'b1, rand_mat(), rand_mat(), ro, re);
    repeat (2) advance(1'b0, a, b, ro, re);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_before_reset actual=%h required=%h", obs_vec(), exp_vec());
    end
    rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (obs_vec() !== 36'h0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_immediate actual=%h required=0", obs_vec());
    end
    repeat (2) begin
      advance(1'b1, rand_mat(), rand_mat(), ro, re);
      checks++;
      if (ro !== 1'b0 || obs_vec() !== 36'h0) begin
        errors++; $display("FAIL mid_during_reset actual=%h ready=%b required=0", obs_vec(), ro);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      advance(1'b0, a, b, ro, re);
      checks++;
      if (obs_vec() !== exp_vec() || in_valid !== 1'b0) begin
        errors++; $display("FAIL mid_after_release k=%0d actual=%h required=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_counter_wrap();
    bit ro, re;
    apply_reset();
    for (int k = 0; k < 10; k++) advance(1'b1, rand_mat(), rand_mat(), ro, re);
    repeat (7) advance(1'b0, rand_mat(), rand_mat(), ro, re);
    checks++;
    if (issued_cnt !== 2'd1) begin
      errors++; $display("FAIL wrap_issued_cnt actual=%0d required=1", issued_cnt);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_idle actual=%h required=%h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    {s_a00, s_a01, s_a10, s_a11, s_b00, s_b01, s_b10, s_b11} = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_set();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
